// File: rtl/nrzi_rx_deser.sv
// nrzi_rx_deser: NRZI line decoder that assembles MSB-first words onto a one-deep valid/ready output register
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   z_in         NRZI line bit, sampled when bit_en=1
//   bit_en       one line bit present this cycle
//   align        synchronous realign; drops the partial word
//   data_out     assembled word, first received bit in the MSB
//   data_valid   data_out holds an unconsumed word
//   data_ready   consumer accepts the word when data_valid=1
//   overrun      sticky flag: a completed word was dropped
//   bit_cnt      bits collected in the current partial word
//   stuff_err    (NRZI_RX_UNSTUFF_EN only) one-cycle pulse on a stuff bit that decoded as 1
// Define NRZI_RX_UNSTUFF_EN to strip a stuff bit after six consecutive decoded 1s.
module nrzi_rx_deser #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             z_in,
    input  logic             bit_en,
    input  logic             align,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
`ifdef NRZI_RX_UNSTUFF_EN
    output logic             stuff_err,
`endif
    output logic [CNT_W-1:0] bit_cnt
);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic             z_prev_q, z_prev_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, dout_q, dout_d, word;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             ovr_q, ovr_d, x, take, done, accept, clr;

`ifdef NRZI_RX_UNSTUFF_EN
    logic [2:0] ones_q, ones_d;
    logic       serr_q, serr_d, stuff;
    // The bit following six decoded 1s is a stuff bit and never carries data.
    assign stuff  = ones_q == 3'd6;
    assign take   = bit_en & ~align & ~stuff;
    assign serr_d = bit_en & ~align & stuff & x;
    assign clr    = align | serr_d;
    assign ones_d = (clr || (bit_en && stuff)) ? 3'd0 : take ? (x ? ones_q + 3'd1 : 3'd0) : ones_q;
    assign stuff_err = serr_q;
`else
    assign take = bit_en & ~align;
    assign clr  = align;
`endif

    assign x        = ~(z_in ^ z_prev_q);
    assign word     = {shreg_q[WIDTH-2:0], x};
    assign done     = take && cnt_q == CNT_W'(WIDTH - 1);
    // A finished word may replace the held one only when that one is consumed this cycle.
    assign accept   = done && (state_q == COLLECT || data_ready);
    assign z_prev_d = align ? 1'b1 : bit_en ? z_in : z_prev_q;
    assign shreg_d  = clr ? '0 : take ? word : shreg_q;
    assign cnt_d    = clr ? '0 : take ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
    assign dout_d   = accept ? word : dout_q;
    assign state_d  = accept ? HOLD : (state_q == HOLD && data_ready) ? COLLECT : state_q;
    assign ovr_d    = align ? 1'b0 : (done && !accept) ? 1'b1 : ovr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            z_prev_q <= 1'b1;
            shreg_q  <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            state_q  <= COLLECT;
            ovr_q    <= 1'b0;
`ifdef NRZI_RX_UNSTUFF_EN
            ones_q   <= '0;
            serr_q   <= 1'b0;
`endif
        end else begin
            z_prev_q <= z_prev_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            state_q  <= state_d;
            ovr_q    <= ovr_d;
`ifdef NRZI_RX_UNSTUFF_EN
            ones_q   <= ones_d;
            serr_q   <= serr_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = state_q == HOLD;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_nrzi_rx_deser.sv
// tb_nrzi_rx_deser: directed bench for nrzi_rx_deser with a queue-based reference model
module tb_nrzi_rx_deser;
    localparam int W = 16;
    localparam int CW = 5;

    logic clock = 0, reset = 0, z_in = 1, bit_en = 0, align = 0, data_ready = 0;
    logic [W-1:0] data_out;
    logic data_valid, overrun;
    logic [CW-1:0] bit_cnt;
`ifdef NRZI_RX_UNSTUFF_EN
    logic stuff_err;
`endif

    nrzi_rx_deser #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .z_in(z_in), .bit_en(bit_en), .align(align),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overrun(overrun),
`ifdef NRZI_RX_UNSTUFF_EN
        .stuff_err(stuff_err),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    logic cur_z = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decoded bits collect in a queue; a full queue becomes a word.
    int bq[$];
    logic m_prev, m_valid, m_ovr, m_serr;
    logic [W-1:0] m_word;
    int m_ones;
    logic [W-1:0] got[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            bq.delete(); m_prev = 1; m_valid = 0; m_ovr = 0; m_word = 0; m_ones = 0; m_serr = 0;
        end else begin
            logic fire, comp, xb;
            logic [W-1:0] w;
            fire = m_valid && data_ready;
            comp = 0;
            m_serr = 0;
            w = 0;
            if (align) begin
                bq.delete(); m_prev = 1; m_ovr = 0; m_ones = 0;
            end else if (bit_en) begin
                xb = (z_in == m_prev);
                m_prev = z_in;
`ifdef NRZI_RX_UNSTUFF_EN
                if (m_ones == 6) begin
                    m_ones = 0;
                    if (xb) begin m_serr = 1; bq.delete(); end
                end else begin
                    bq.push_back(int'(xb));
                    m_ones = xb ? m_ones + 1 : 0;
                end
`else
                bq.push_back(int'(xb));
`endif
                if (bq.size() == W) begin
                    comp = 1;
                    for (int i = 0; i < W; i++) w += W'(bq[i]) << (W - 1 - i);
                    bq.delete();
                end
            end
            if (comp && (!m_valid || data_ready)) begin m_word = w; m_valid = 1; end
            else if (comp) m_ovr = 1;
            else if (fire) m_valid = 0;
        end
    end

    always @(negedge clock) if (reset) begin
        chk("data_out", 32'(data_out), 32'(m_word));
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bit_cnt", 32'(bit_cnt), 32'(bq.size()));
`ifdef NRZI_RX_UNSTUFF_EN
        chk("stuff_err", 32'(stuff_err), 32'(m_serr));
`endif
        if (data_valid && data_ready) got.push_back(data_out);
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic send_line_bit(input logic z);
        z_in = z; cur_z = z; bit_en = 1;
        step();
        bit_en = 0;
    endtask

    task automatic send_bit(input logic d);
        send_line_bit(d ? cur_z : ~cur_z);
    endtask

    task automatic send_line(input logic [W-1:0] l);
        for (int i = W - 1; i >= 0; i--) send_line_bit(l[i]);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        #9 reset = 1;
        // basic decode of the encoder output for 0xF161
        send_line(16'hF4EB);
        chk("t1_data", 32'(data_out), 32'h0000F161);
        chk("t1_valid", 32'(data_valid), 1);
        chk("t1_ovr", 32'(overrun), 0);
        // back-to-back words with the consumer always ready
        data_ready = 1;
        step();
        got.delete();
        send_line(16'hF4EB);
        send_word(16'hCF0C);
        step();
        chk("t2_count", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("t2_w0", 32'(got[0]), 32'h0000F161);
            chk("t2_w1", 32'(got[1]), 32'h0000CF0C);
        end
        chk("t2_ovr", 32'(overrun), 0);
        // overrun when the consumer stalls
        data_ready = 0;
        send_word(16'hF161);
        send_word(16'h1234);
        chk("t3_data", 32'(data_out), 32'h0000F161);
        chk("t3_ovr", 32'(overrun), 1);
        data_ready = 1;
        step();
        data_ready = 0;
        chk("t3_valid", 32'(data_valid), 0);
        chk("t3_ovr_sticky", 32'(overrun), 1);
        // align in the middle of a word, coincident with a bit
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(0);
        chk("t4_cnt5", 32'(bit_cnt), 5);
        align = 1; bit_en = 1; z_in = ~cur_z;
        step();
        align = 0; bit_en = 0; cur_z = 1;
        chk("t4_cnt0", 32'(bit_cnt), 0);
        send_word(16'h8C00);
        chk("t4_data", 32'(data_out), 32'h00008C00);
        chk("t4_ovr", 32'(overrun), 0);
        data_ready = 1;
        step();
        // asynchronous reset mid-word
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        chk("t5_cnt9", 32'(bit_cnt), 9);
        reset = 0;
        #1;
        chk("t5_rst_data", 32'(data_out), 0);
        chk("t5_rst_valid", 32'(data_valid), 0);
        chk("t5_rst_cnt", 32'(bit_cnt), 0);
        chk("t5_rst_ovr", 32'(overrun), 0);
        #2 reset = 1;
        cur_z = 1;
        step();
        send_word(16'hA5C3);
        chk("t5_data", 32'(data_out), 32'h0000A5C3);
`ifdef NRZI_RX_UNSTUFF_EN
        // six 1s, a 0 stuff bit, then ten data bits
        step();
        for (int i = 0; i < 6; i++) send_bit(1);
        send_bit(0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(0);
        send_bit(1); send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        chk("t6_data", 32'(data_out), 32'h0000FE9C);
        step();
        for (int i = 0; i < 7; i++) send_bit(1);
        chk("t6_serr", 32'(stuff_err), 1);
        chk("t6_cnt", 32'(bit_cnt), 0);
        step();
        chk("t6_serr_pulse", 32'(stuff_err), 0);
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
